// File: rtl/unidade_mult_pkg.sv
// Shared widths and state encoding for the sequential multiplier.
// Optional feature macro: MULT_ALTO_EN (high product word and signed handling).
package mult_pkg;

   localparam int unsigned LARGURA_MULT = 64;
   localparam int unsigned LARGURA_CONT = 6;

   typedef enum logic [1:0] {OCIOSO, CALCULA, AJUSTE} estado_mult_t;

endpackage

// File: rtl/unidade_mult_if.sv
// Start/operand/result bundle between the control unit and the multiplier.
// Optional feature macro: MULT_ALTO_EN adds resultadoAlto and makes comSinal meaningful.
interface unidade_mult_if
   import mult_pkg::*;
#(
   parameter int unsigned LARGURA = LARGURA_MULT
);

   logic               inicio;
   logic [LARGURA-1:0] operandoA;
   logic [LARGURA-1:0] operandoB;
   logic               comSinal;
   logic [LARGURA-1:0] resultado;
`ifdef MULT_ALTO_EN
   logic [LARGURA-1:0] resultadoAlto;
`endif
   logic               ocupado;
   logic               pronto;

`ifdef MULT_ALTO_EN
   modport master (
      output inicio, operandoA, operandoB, comSinal,
      input  resultado, resultadoAlto, ocupado, pronto
   );
   modport slave (
      input  inicio, operandoA, operandoB, comSinal,
      output resultado, resultadoAlto, ocupado, pronto
   );
`else
   modport master (
      output inicio, operandoA, operandoB, comSinal,
      input  resultado, ocupado, pronto
   );
   modport slave (
      input  inicio, operandoA, operandoB, comSinal,
      output resultado, ocupado, pronto
   );
`endif

endinterface

// File: rtl/unidade_mult.sv
// Sequential shift-and-add multiplier: one partial product per cycle, 66-cycle latency.
// Optional feature macro: MULT_ALTO_EN (resultadoAlto port, signed via |A|*|B| and final negation).
module unidade_mult
   import mult_pkg::*;
#(
   parameter int unsigned LARGURA = LARGURA_MULT
) (
   input  logic           clk,
   input  logic           reset,
   unidade_mult_if.slave  bus
);

   localparam int unsigned CW = $clog2(LARGURA);
   localparam logic [CW-1:0] ULTIMO = CW'(LARGURA - 1);

   estado_mult_t           estado;
   logic [2*LARGURA-1:0]   acc;
   logic [LARGURA-1:0]     mcand;
   logic [CW-1:0]          cont;
   logic [LARGURA:0]       soma;
   logic [2*LARGURA-1:0]   produto;
   logic [LARGURA-1:0]     op_a;
   logic [LARGURA-1:0]     op_b;

`ifdef MULT_ALTO_EN
   logic neg;

   always_comb begin
      op_a = (bus.comSinal && bus.operandoA[LARGURA-1]) ? -bus.operandoA : bus.operandoA;
      op_b = (bus.comSinal && bus.operandoB[LARGURA-1]) ? -bus.operandoB : bus.operandoB;
      produto = neg ? -acc : acc;
   end
`else
   logic sinal_unused;

   assign sinal_unused = bus.comSinal;

   always_comb begin
      op_a    = bus.operandoA;
      op_b    = bus.operandoB;
      produto = acc;
   end
`endif

   // Carry out of the upper-half add becomes the new MSB after the shift.
   always_comb begin
      soma = {1'b0, acc[2*LARGURA-1:LARGURA]} + (acc[0] ? {1'b0, mcand} : '0);
   end

   assign bus.ocupado = (estado != OCIOSO);

   always_ff @(posedge clk) begin
      if (reset) begin
         estado            <= OCIOSO;
         acc               <= '0;
         mcand             <= '0;
         cont              <= '0;
         bus.resultado     <= '0;
         bus.pronto        <= 1'b0;
`ifdef MULT_ALTO_EN
         neg               <= 1'b0;
         bus.resultadoAlto <= '0;
`endif
      end else begin
         bus.pronto <= 1'b0;
         case (estado)
            OCIOSO: begin
               if (bus.inicio) begin
                  acc    <= {{LARGURA{1'b0}}, op_b};
                  mcand  <= op_a;
                  cont   <= '0;
`ifdef MULT_ALTO_EN
                  neg    <= bus.comSinal & (bus.operandoA[LARGURA-1] ^ bus.operandoB[LARGURA-1]);
`endif
                  estado <= CALCULA;
               end
            end
            CALCULA: begin
               acc  <= {soma, acc[LARGURA-1:1]};
               cont <= cont + 1'b1;
               if (cont == ULTIMO) begin
                  estado <= AJUSTE;
               end
            end
            AJUSTE: begin
               bus.resultado     <= produto[LARGURA-1:0];
`ifdef MULT_ALTO_EN
               bus.resultadoAlto <= produto[2*LARGURA-1:LARGURA];
`endif
               bus.pronto        <= 1'b1;
               estado            <= OCIOSO;
            end
            default: estado <= OCIOSO;
         endcase
      end
   end

endmodule

// File: tb/tb_unidade_mult.sv
// Directed-vector bench for unidade_mult: timing, ignored restarts, reset abort, back-to-back.
// Signed/high-word vectors are built only with MULT_ALTO_EN.
module tb_unidade_mult;

   logic clk = 1'b0;
   logic reset;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   unidade_mult_if #(.LARGURA(64)) bus ();

   unidade_mult #(.LARGURA(64)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
      end
   endtask

   // Called at a negedge; leaves the bench one negedge after the accepting edge.
   task automatic start(input logic [63:0] a, input logic [63:0] b, input logic s);
      bus.operandoA = a;
      bus.operandoB = b;
      bus.comSinal  = s;
      bus.inicio    = 1'b1;
      @(negedge clk);
      bus.inicio    = 1'b0;
      bus.operandoA = 64'hDEAD_BEEF_0BAD_F00D;
      bus.operandoB = 64'h1234_5678_9ABC_DEF0;
      bus.comSinal  = ~s;
   endtask

   // Counts cycles from the accepting edge until pronto, optionally re-pulsing inicio.
   task automatic wait_pronto(input int repulse_at, input logic [63:0] held,
                              output int cycles, output int busy, output int early);
      cycles = 1;
      busy   = bus.ocupado ? 1 : 0;
      early  = 0;
      while (!bus.pronto && cycles < 200) begin
         if (cycles == repulse_at) begin
            bus.inicio    = 1'b1;
            bus.operandoA = 64'd7;
            bus.operandoB = 64'd7;
         end else begin
            bus.inicio = 1'b0;
         end
         if (bus.resultado !== held) early++;
         @(negedge clk);
         cycles++;
         if (bus.ocupado) busy++;
      end
      bus.inicio = 1'b0;
   endtask

   task automatic count_prontos(input int n, output int p);
      p = 0;
      repeat (n) begin
         @(negedge clk);
         if (bus.pronto) p++;
      end
   endtask

   initial begin
      int cyc, busy, early, p;
      reset         = 1'b1;
      bus.inicio    = 1'b0;
      bus.operandoA = '0;
      bus.operandoB = '0;
      bus.comSinal  = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("reset_resultado", bus.resultado, 64'd0);
      check("reset_ocupado", {63'd0, bus.ocupado}, 64'd0);
      check("reset_pronto", {63'd0, bus.pronto}, 64'd0);
`ifdef MULT_ALTO_EN
      check("reset_alto", bus.resultadoAlto, 64'd0);
`endif

      // 3 x 5: latency and busy window
      start(64'd3, 64'd5, 1'b0);
      check("busy_after_accept", {63'd0, bus.ocupado}, 64'd1);
      wait_pronto(0, 64'd0, cyc, busy, early);
      check("lat_3x5", cyc, 66);
      check("busy_3x5", busy, 65);
      check("held_before_3x5", early, 0);
      check("res_3x5", bus.resultado, 64'd15);
`ifdef MULT_ALTO_EN
      check("alto_3x5", bus.resultadoAlto, 64'd0);
`endif
      @(negedge clk);
      check("pronto_pulse", {63'd0, bus.pronto}, 64'd0);
      check("res_hold", bus.resultado, 64'd15);

      // all-ones x 2 unsigned
      start(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0);
      wait_pronto(0, 64'd15, cyc, busy, early);
      check("lat_ffx2", cyc, 66);
      check("res_ffx2", bus.resultado, 64'hFFFF_FFFF_FFFF_FFFE);
`ifdef MULT_ALTO_EN
      check("alto_ffx2", bus.resultadoAlto, 64'd1);
      @(negedge clk);
      start(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1);
      wait_pronto(0, 64'hFFFF_FFFF_FFFF_FFFE, cyc, busy, early);
      check("res_m1x2_s", bus.resultado, 64'hFFFF_FFFF_FFFF_FFFE);
      check("alto_m1x2_s", bus.resultadoAlto, 64'hFFFF_FFFF_FFFF_FFFF);
      @(negedge clk);
      start(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
      wait_pronto(0, 64'hFFFF_FFFF_FFFF_FFFE, cyc, busy, early);
      check("res_min2_s", bus.resultado, 64'd0);
      check("alto_min2_s", bus.resultadoAlto, 64'h4000_0000_0000_0000);
`endif

      // inicio re-pulsed while busy is ignored
      @(negedge clk);
      start(64'd3, 64'd5, 1'b0);
      wait_pronto(10, bus.resultado, cyc, busy, early);
      check("lat_repulse", cyc, 66);
      check("res_repulse", bus.resultado, 64'd15);
      count_prontos(80, p);
      check("no_extra_pronto", p, 0);

      // reset mid-operation aborts
      start(64'd3, 64'd5, 1'b0);
      repeat (29) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_resultado", bus.resultado, 64'd0);
      check("abort_ocupado", {63'd0, bus.ocupado}, 64'd0);
      check("abort_pronto", {63'd0, bus.pronto}, 64'd0);
      count_prontos(80, p);
      check("abort_no_pronto", p, 0);
      start(64'd6, 64'd7, 1'b0);
      wait_pronto(0, 64'd0, cyc, busy, early);
      check("lat_6x7", cyc, 66);
      check("res_6x7", bus.resultado, 64'd42);

      // back-to-back: start in the pronto cycle
      @(negedge clk);
      start(64'd3, 64'd5, 1'b0);
      wait_pronto(0, 64'd42, cyc, busy, early);
      check("res_b2b_first", bus.resultado, 64'd15);
      start(64'd9, 64'd9, 1'b0);
      wait_pronto(0, 64'd15, cyc, busy, early);
      check("lat_b2b", cyc, 66);
      check("held_b2b", early, 0);
      check("busy_b2b", busy, 65);
      check("res_9x9", bus.resultado, 64'd81);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
